// File: rtl/mfp_eic_sink.sv
// Purpose : core-side EIC consumer; arbitrates RIPL vs current IPL, acknowledges, enters and nests handlers.
// Latency : accept in cycle N -> EIC_IAck in N+1 -> new IPL/handler_valid in N+2 -> next accept in N+3.
// Backpres: requests at or below IPL, or with the priority stack full, stay pending and are not acknowledged.
//
// Ports:
//   CLK, RESETn                 clock (rising edge), synchronous active-low reset
//   EIC_Present/Interrupt/Vector/Offset/ShadowSet   controller request bundle
//   int_enable, eret            global interrupt enable, handler-return pulse
//   EIC_IAck, EIC_IPL           acknowledge pulse and current priority level back to the controller
//   handler_valid/handler_addr  one-cycle handler-entry pulse and entered handler address
//   active_vector/shadowset     context of the running handler
//   depth, nest_full, eret_err  nesting depth, stack-full flag, sticky eret-underflow flag
//
// Build option: define EIC_SINK_NESTING_EN for a STACK_DEPTH-entry stack with preemption;
// otherwise a single handler level is supported (accept only at depth 0).
module mfp_eic_sink #(
  parameter int          STACK_DEPTH = 4,
  parameter logic [31:0] EBASE       = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        EIC_Present,
  input  logic [7:0]  EIC_Interrupt,
  input  logic [5:0]  EIC_Vector,
  input  logic [17:1] EIC_Offset,
  input  logic [3:0]  EIC_ShadowSet,
  input  logic        int_enable,
  input  logic        eret,
  output logic        EIC_IAck,
  output logic [7:0]  EIC_IPL,
  output logic        handler_valid,
  output logic [31:0] handler_addr,
  output logic [5:0]  active_vector,
  output logic [3:0]  active_shadowset,
  output logic [2:0]  depth,
  output logic        nest_full,
  output logic        eret_err
);

`ifdef EIC_SINK_NESTING_EN
  localparam bit NEST_EN = 1'b1;
`else
  localparam bit NEST_EN = 1'b0;
`endif

  // Number of stack entries actually built; one when nesting is disabled.
  localparam int         LIMIT    = NEST_EN ? STACK_DEPTH : 1;
  localparam logic [2:0] LIMIT_M1 = 3'(LIMIT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_ACK,
    S_ENTER
  } state_t;

  state_t      state;

  // Request captured in the accept cycle; later changes on the bus are ignored.
  logic [7:0]  lat_ripl;
  logic [5:0]  lat_vec;
  logic [16:0] lat_off;
  logic [3:0]  lat_ss;

  // Saved context of interrupted levels; entry i holds the context present at depth i.
  logic [7:0]  stk_ipl [LIMIT];
  logic [5:0]  stk_vec [LIMIT];
  logic [3:0]  stk_ss  [LIMIT];

  logic [7:0]  top_ipl;
  logic [5:0]  top_vec;
  logic [3:0]  top_ss;
  logic        accept;

  // Entry to restore on eret: the one pushed when the current depth was entered.
  always_comb begin
    top_ipl = '0;
    top_vec = '0;
    top_ss  = '0;
    for (int i = 0; i < LIMIT; i++) begin
      if (depth == 3'(i + 1)) begin
        top_ipl = stk_ipl[i];
        top_vec = stk_vec[i];
        top_ss  = stk_ss[i];
      end
    end
  end

  // nest_full also covers the single-level build, where it means depth != 0.
  // eret has priority: a simultaneous request is re-evaluated against the restored IPL.
  assign accept = EIC_Present & int_enable & (EIC_Interrupt > EIC_IPL) & ~nest_full & ~eret;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state            <= S_RUN;
      EIC_IAck         <= 1'b0;
      handler_valid    <= 1'b0;
      eret_err         <= 1'b0;
      EIC_IPL          <= '0;
      handler_addr     <= '0;
      active_vector    <= '0;
      active_shadowset <= '0;
      depth            <= '0;
      nest_full        <= 1'b0;
      lat_ripl         <= '0;
      lat_vec          <= '0;
      lat_off          <= '0;
      lat_ss           <= '0;
      for (int i = 0; i < LIMIT; i++) begin
        stk_ipl[i] <= '0;
        stk_vec[i] <= '0;
        stk_ss[i]  <= '0;
      end
    end else begin
      EIC_IAck      <= 1'b0;
      handler_valid <= 1'b0;
      case (state)
        S_RUN: begin
          if (eret) begin
            if (depth != 3'd0) begin
              EIC_IPL          <= top_ipl;
              active_vector    <= top_vec;
              active_shadowset <= top_ss;
              depth            <= depth - 3'd1;
              nest_full        <= 1'b0;
            end else begin
              eret_err <= 1'b1;
            end
          end else if (accept) begin
            lat_ripl <= EIC_Interrupt;
            lat_vec  <= EIC_Vector;
            lat_off  <= EIC_Offset;
            lat_ss   <= EIC_ShadowSet;
            EIC_IAck <= 1'b1;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          for (int i = 0; i < LIMIT; i++) begin
            if (depth == 3'(i)) begin
              stk_ipl[i] <= EIC_IPL;
              stk_vec[i] <= active_vector;
              stk_ss[i]  <= active_shadowset;
            end
          end
          EIC_IPL          <= lat_ripl;
          active_vector    <= lat_vec;
          active_shadowset <= lat_ss;
          depth            <= depth + 3'd1;
          nest_full        <= (depth == LIMIT_M1);
          // Offset is in halfwords; the add wraps modulo 2^32.
          handler_addr     <= EBASE + {14'd0, lat_off, 1'b0};
          handler_valid    <= 1'b1;
          state            <= S_ENTER;
        end
        S_ENTER: begin
          state <= S_RUN;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule
